// File: rtl/crc_pkg.sv
// crc_pkg: frame FSM state encoding and default polynomial constants for the serial CRC engine.
package crc_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, SHIFT_IN = 2'b01, SHIFT_OUT = 2'b10} state_e;
   localparam logic [7:0] DEF_TAPS      = 8'b0100_0100;
   localparam logic [7:0] DEF_SEED      = 8'hD8;
   localparam logic [7:0] DEF_FINAL_XOR = 8'h00;
endpackage

// File: rtl/crc_serial_engine_if.sv
// crc_serial_engine_if: serial frame input and CRC output handshake of the CRC engine.
interface crc_serial_engine_if;
   logic ACTIVE, DATA, CRC, Valid, Busy, Done;
   modport master (output ACTIVE, DATA, input CRC, Valid, Busy, Done);
   modport slave (input ACTIVE, DATA, output CRC, Valid, Busy, Done);
endinterface

// File: rtl/crc_lfsr_core.sv
// crc_lfsr_core: LFSR register with seed-load, step and shift-out; after the remainder is captured the
// same register drains it serially. Optional final XOR under CRC_FINAL_XOR_EN.
module crc_lfsr_core import crc_pkg::*; #(
   parameter int                   CRC_WIDTH = 8,
   parameter logic [CRC_WIDTH-1:0] TAPS      = CRC_WIDTH'(DEF_TAPS),
   parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'(DEF_SEED),
   parameter logic [CRC_WIDTH-1:0] FINAL_XOR = CRC_WIDTH'(DEF_FINAL_XOR),
   parameter logic                 MSB_FIRST = 1'b0
) (
   input  logic CLK,
   input  logic RST,
   input  logic start,
   input  logic step_en,
   input  logic dump,
   input  logic shift_en,
   input  logic din,
   output logic first_bit,
   output logic head_bit
);
   logic [CRC_WIDTH-1:0] lfsr_q, lfsr_d, rem;
   function automatic logic [CRC_WIDTH-1:0] step(input logic [CRC_WIDTH-1:0] v, input logic d);
      logic fb;
      fb = d ^ v[0];
      return {fb, v[CRC_WIDTH-1:1]} ^ ({CRC_WIDTH{fb}} & {1'b0, TAPS[CRC_WIDTH-2:0]});
   endfunction
   function automatic logic [CRC_WIDTH-1:0] advance(input logic [CRC_WIDTH-1:0] v);
      return MSB_FIRST ? {v[CRC_WIDTH-2:0], 1'b0} : {1'b0, v[CRC_WIDTH-1:1]};
   endfunction
   function automatic logic head(input logic [CRC_WIDTH-1:0] v);
      return MSB_FIRST ? v[CRC_WIDTH-1] : v[0];
   endfunction
`ifdef CRC_FINAL_XOR_EN
   assign rem = lfsr_q ^ FINAL_XOR;
`else
   assign rem = lfsr_q;
`endif
   // dump stores the remainder already advanced by one, since its head bit leaves on the same edge
   always_comb
      lfsr_d = start    ? step(SEED, din)   :
               step_en  ? step(lfsr_q, din) :
               dump     ? advance(rem)      :
               shift_en ? advance(lfsr_q)   : lfsr_q;
   always_ff @(posedge CLK)
      lfsr_q <= RST ? SEED : lfsr_d;
   assign first_bit = head(rem);
   assign head_bit  = head(lfsr_q);
endmodule

// File: rtl/crc_serial_engine.sv
// crc_serial_engine: serial CRC generator with frame FSM, reseed at every frame start and a Done pulse.
// Define CRC_FINAL_XOR_EN to XOR the remainder with FINAL_XOR before it is emitted.
module crc_serial_engine import crc_pkg::*; #(
   parameter int                   CRC_WIDTH = 8,
   parameter logic [CRC_WIDTH-1:0] TAPS      = CRC_WIDTH'(DEF_TAPS),
   parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'(DEF_SEED),
   parameter logic                 MSB_FIRST = 1'b0,
   parameter logic [CRC_WIDTH-1:0] FINAL_XOR = CRC_WIDTH'(DEF_FINAL_XOR)
) (
   input logic                CLK,
   input logic                RST,
   crc_serial_engine_if.slave bus
);
   localparam int            CW   = $clog2(CRC_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(CRC_WIDTH);
   state_e        state_q, state_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic          crc_q, crc_d, valid_q, valid_d, done_q, done_d;
   logic          start, step_en, dump, shift_en, first_bit, head_bit;
   crc_lfsr_core #(
      .CRC_WIDTH(CRC_WIDTH), .TAPS(TAPS), .SEED(SEED), .FINAL_XOR(FINAL_XOR), .MSB_FIRST(MSB_FIRST)
   ) u_core (
      .CLK(CLK), .RST(RST), .start(start), .step_en(step_en), .dump(dump), .shift_en(shift_en),
      .din(bus.DATA), .first_bit(first_bit), .head_bit(head_bit)
   );
   always_comb begin
      state_d   = state_q;
      out_cnt_d = out_cnt_q;
      crc_d     = 1'b0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      start     = 1'b0;
      step_en   = 1'b0;
      dump      = 1'b0;
      shift_en  = 1'b0;
      case (state_q)
         IDLE: if (bus.ACTIVE) begin
            start   = 1'b1;
            state_d = SHIFT_IN;
         end
         SHIFT_IN: if (bus.ACTIVE) step_en = 1'b1;
         else begin
            dump      = 1'b1;
            crc_d     = first_bit;
            valid_d   = 1'b1;
            out_cnt_d = CW'(1);
            state_d   = SHIFT_OUT;
         end
         SHIFT_OUT: if (out_cnt_q < LAST) begin
            shift_en  = 1'b1;
            crc_d     = head_bit;
            valid_d   = 1'b1;
            out_cnt_d = out_cnt_q + CW'(1);
         end else begin
            done_d    = 1'b1;
            out_cnt_d = '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         out_cnt_q <= '0;
         crc_q     <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_cnt_q <= out_cnt_d;
         crc_q     <= crc_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end
   assign bus.CRC   = crc_q;
   assign bus.Valid = valid_q;
   assign bus.Done  = done_q;
   assign bus.Busy  = state_q != IDLE;
endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: three engine configurations fed identical random frames; a monitor checks every
// output bit, latency, Valid length, Done and Busy against a queue filled by a reference model.
module tb_crc_serial_engine;
   logic clk = 1'b0, rst = 1'b1, active = 1'b0, data = 1'b0;
   always #5 clk = ~clk;

   crc_serial_engine_if if0 (), if1 (), if2 ();
   assign if0.ACTIVE = active;
   assign if0.DATA   = data;
   assign if1.ACTIVE = active;
   assign if1.DATA   = data;
   assign if2.ACTIVE = active;
   assign if2.DATA   = data;

   crc_serial_engine #(.CRC_WIDTH(8), .TAPS(8'h44), .SEED(8'hD8), .MSB_FIRST(1'b0), .FINAL_XOR(8'h3C))
      dut0 (.CLK(clk), .RST(rst), .bus(if0));
   crc_serial_engine #(.CRC_WIDTH(8), .TAPS(8'h00), .SEED(8'h00), .MSB_FIRST(1'b0), .FINAL_XOR(8'hFF))
      dut1 (.CLK(clk), .RST(rst), .bus(if1));
   crc_serial_engine #(.CRC_WIDTH(8), .TAPS(8'h00), .SEED(8'hD8), .MSB_FIRST(1'b1), .FINAL_XOR(8'h00))
      dut2 (.CLK(clk), .RST(rst), .bus(if2));

   logic crc_o [3], valid_o [3], busy_o [3], done_o [3];
   assign crc_o[0]   = if0.CRC;
   assign crc_o[1]   = if1.CRC;
   assign crc_o[2]   = if2.CRC;
   assign valid_o[0] = if0.Valid;
   assign valid_o[1] = if1.Valid;
   assign valid_o[2] = if2.Valid;
   assign busy_o[0]  = if0.Busy;
   assign busy_o[1]  = if1.Busy;
   assign busy_o[2]  = if2.Busy;
   assign done_o[0]  = if0.Done;
   assign done_o[1]  = if1.Done;
   assign done_o[2]  = if2.Done;

   bit [7:0] taps_c [3] = '{8'h44, 8'h00, 8'h00};
   bit [7:0] seed_c [3] = '{8'hD8, 8'h00, 8'hD8};
   bit [7:0] fx_c   [3] = '{8'h3C, 8'hFF, 8'h00};
   bit       msb_c  [3] = '{1'b0, 1'b0, 1'b1};

   bit  exp_q   [3][$];
   int  start_q [3][$];
   int  run [3];
   bit  pv  [3];
   int  cyc = 0;
   bit  rst_prev = 1'b1;
   int  checks = 0, failures = 0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_prev <= rst;
   end

   task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, i, cyc, act, exp);
      end
   endtask

   task automatic fail_now(input int i, input string name);
      checks++;
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=output-present expected=none", name, i, cyc);
   endtask

   // Bit-by-bit application of the textbook LFSR rule, then the optional final mask.
   function automatic bit [7:0] remainder(input int i, input int n, input logic [63:0] bits);
      bit [7:0] v, nv;
      bit fb;
      v = seed_c[i];
      for (int k = 0; k < n; k++) begin
         fb = bits[k] ^ v[0];
         for (int j = 0; j < 7; j++) nv[j] = v[j+1] ^ (fb & taps_c[i][j]);
         nv[7] = fb;
         v = nv;
      end
`ifdef CRC_FINAL_XOR_EN
      v = v ^ fx_c[i];
`endif
      return v;
   endfunction

   task automatic push_frame(input int n, input logic [63:0] bits);
      bit [7:0] r;
      for (int i = 0; i < 3; i++) begin
         r = remainder(i, n, bits);
         for (int j = 0; j < 8; j++) exp_q[i].push_back(msb_c[i] ? r[7-j] : r[j]);
         start_q[i].push_back(cyc + 1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int n, input logic [63:0] bits, input bit toggle, input int idle,
                             input bit abort);
      for (int k = 0; k < n; k++) begin
         active = 1'b1;
         data   = bits[k];
         tick();
      end
      active = 1'b0;
      data   = 1'($urandom);
      push_frame(n, bits);
      tick();
      if (abort) begin
         repeat (3) tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
      end else begin
         for (int g = 0; g < 8; g++) begin
            active = toggle ? 1'($urandom) : 1'b0;
            data   = 1'($urandom);
            tick();
         end
         active = 1'b0;
      end
      repeat (idle) tick();
   endtask

   always @(negedge clk) begin
      if (cyc > 0) begin
         for (int i = 0; i < 3; i++) begin
            if (rst_prev) begin
               chk(i, "rst_valid", valid_o[i], 0);
               chk(i, "rst_crc", crc_o[i], 0);
               chk(i, "rst_busy", busy_o[i], 0);
               chk(i, "rst_done", done_o[i], 0);
               exp_q[i].delete();
               start_q[i].delete();
               run[i] = 0;
               pv[i]  = 1'b0;
            end else begin
               chk(i, "done", done_o[i], pv[i] && !valid_o[i]);
               if (valid_o[i]) begin
                  if (!pv[i]) begin
                     if (start_q[i].size() == 0) fail_now(i, "latency_unexpected");
                     else chk(i, "latency", cyc, start_q[i].pop_front());
                  end
                  if (exp_q[i].size() == 0) fail_now(i, "crc_unexpected");
                  else chk(i, "crc_bit", crc_o[i], exp_q[i].pop_front());
                  chk(i, "busy_out", busy_o[i], 1);
                  run[i]++;
               end else begin
                  chk(i, "crc_idle", crc_o[i], 0);
                  if (pv[i]) begin
                     chk(i, "valid_len", run[i], 8);
                     chk(i, "busy_done", busy_o[i], 0);
                     run[i] = 0;
                  end
               end
               pv[i] = valid_o[i];
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      send_frame(8, 64'hA5, 1'b0, 2, 1'b0);
      send_frame(8, 64'h00, 1'b0, 0, 1'b0);
      send_frame(13, {$urandom, $urandom}, 1'b0, 1, 1'b0);
      send_frame(8, 64'hA5, 1'b1, 0, 1'b0);
      send_frame(1, {$urandom, $urandom}, 1'b1, 0, 1'b0);
      send_frame(20, {$urandom, $urandom}, 1'b0, 2, 1'b1);
      send_frame(10, {$urandom, $urandom}, 1'b0, 1, 1'b0);
      repeat (30)
         send_frame($urandom_range(1, 64), {$urandom, $urandom}, 1'($urandom), $urandom_range(0, 3), 1'b0);
      repeat (12) tick();
      for (int i = 0; i < 3; i++) begin
         chk(i, "drain_bits", exp_q[i].size(), 0);
         chk(i, "drain_frames", start_q[i].size(), 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
- Parametrised serial CRC generator for the CRC subsystem.
- Consumes a serial data frame qualified by ACTIVE, then emits the CRC_WIDTH-bit remainder serially, qualified by Valid.
- Differs from the fixed 8-bit LFSR in four ways: configurable width, taps, seed and output order; automatic reseed at each frame start (no reset needed between frames); explicit frame FSM; completion pulse.

Parameters:
- CRC_WIDTH, 8, LFSR/CRC length in bits (2..32).
- TAPS, 8'b0100_0100, feedback tap mask; bit i set means fb is XORed into next[i] (i < CRC_WIDTH-1).
- SEED, 8'hD8, LFSR value loaded at every frame start and at reset.
- MSB_FIRST, 0, output order: 0 = lfsr[0] first, 1 = lfsr[CRC_WIDTH-1] first.
- FINAL_XOR, 8'h00, XOR mask applied at end of input; used only with CRC_FINAL_XOR_EN.

Ports:
- CLK  in  1  Clock; all logic on rising edge.
- RST  in  1  Synchronous active-high reset.
- ACTIVE  in  1  Frame qualifier; DATA is consumed on every cycle ACTIVE=1 in IDLE/SHIFT_IN.
- DATA  in  1  Serial input bit.
- CRC  out  1  Serial CRC output bit (registered).
- Valid  out  1  High exactly CRC_WIDTH consecutive cycles while CRC carries the remainder.
- Busy  out  1  High in SHIFT_IN and SHIFT_OUT.
- Done  out  1  One-cycle pulse in the cycle after the last Valid bit.

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE, lfsr=SEED, CRC=0, Valid=0, Busy=0, Done=0, out_cnt=0. Reset mid-frame aborts the frame with no partial output.
- LFSR step(v,d): fb = d ^ v[0]; next[i] = v[i+1] ^ (fb & TAPS[i]) for i < CRC_WIDTH-1; next[CRC_WIDTH-1] = fb.
- IDLE:
  - ACTIVE=1: lfsr <= step(SEED, DATA), go to SHIFT_IN.
  - ACTIVE=0: hold; Done=0.
- SHIFT_IN:
  - ACTIVE=1: lfsr <= step(lfsr, DATA).
  - ACTIVE=0: DATA ignored. Remainder R = lfsr (R = lfsr ^ FINAL_XOR if the feature is on). Register the first output bit of R on this edge, set Valid=1, out_cnt=1, go to SHIFT_OUT, shift R so the next bit is presented.
- SHIFT_OUT:
  - Each cycle presents the next bit (LSB-first or MSB-first per MSB_FIRST); out_cnt increments.
  - After CRC_WIDTH bits: Valid=0, Done=1 for one cycle, go to IDLE.
  - ACTIVE is ignored during SHIFT_OUT. A new frame starts only when ACTIVE is sampled high in IDLE.
  - If ACTIVE is high on the Done cycle, that cycle is IDLE: the frame starts and its first bit is consumed.
- Latency: first Valid bit appears one edge after the first cycle ACTIVE is sampled low.
- Frame length: any length ≥1 bit is legal; length is unbounded and there is no internal length counter.
- Busy is low in IDLE, including the cycle Done pulses.
- out_cnt width is $clog2(CRC_WIDTH+1) and saturates logically at CRC_WIDTH.
- CRC output is held at 0 whenever Valid=0.

Optional Feature:
- Macro: CRC_FINAL_XOR_EN.
- Defined: remainder is XORed with FINAL_XOR at the SHIFT_IN→SHIFT_OUT transition.
- Undefined: FINAL_XOR is ignored, the XOR logic is not synthesised, and the raw lfsr is emitted.

Decomposition:
- Package crc_pkg holds:
  - state encoding constants: IDLE=2'b00, SHIFT_IN=2'b01, SHIFT_OUT=2'b10;
  - default TAPS/SEED constants.
- One sub-module, crc_lfsr_core:
  - contains the lfsr register and step() logic;
  - load-seed, step and shift-out controls;
  - parameters CRC_WIDTH/TAPS/SEED.
- FSM, counter and output registers stay in crc_serial_engine.

Test Plan:
- Pure shift: TAPS=0, SEED=0, CRC_WIDTH=8, frame 8'hA5 sent LSB first → Valid for 8 cycles, CRC bits LSB-first = 8'hA5; Done one cycle after the last bit.
- Seed recirculation: TAPS=0, SEED=8'hD8, data 8'h00 → output 8'hD8. Repeat with MSB_FIRST=1 → bit sequence 1,1,0,1,1,0,0,0.
- Back-to-back frames without RST: zero-data frame with any TAPS and SEED=0 → output 8'h00. Next frame with ACTIVE high on the Done cycle still reseeds and produces the correct golden-model CRC.
- Reset mid-frame: RST at the 4th SHIFT_OUT cycle → next edge Valid=0, CRC=0, Busy=0, no Done. A following frame matches the golden model.
- ACTIVE toggled during SHIFT_OUT → output unchanged, exactly 8 Valid cycles.
- With CRC_FINAL_XOR_EN, FINAL_XOR=8'hFF on the pure-shift case with 8'hA5 → output 8'h5A. Without the macro → 8'hA5.
